fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter WIDTH, default 2, bundles per cycle on each side (fetch width = decode width).
REQ-002 Parameter DEPTH, default 8, queue entries; power of two, >= 2*WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  pipeline flush/redirect; discard all contents.
REQ-006 in_bundle  input  WIDTH x fet_bundle_t  fetched instructions; per-slot valid field marks occupancy, slots in program order.
REQ-007 in_ready  output  1  queue accepts a full group this cycle.
REQ-008 out_bundle  output  WIDTH x fet_bundle_t  oldest entries to decoder, slot 0 oldest.
REQ-009 out_deq  input  $clog2(WIDTH+1)  number of out_bundle slots consumed by decoder this cycle.
REQ-010 count  output  $clog2(DEPTH+1)  current occupancy.
REQ-011 stall_cnt  output  32  full-stall cycle counter (present only with FETQ_STAT_EN).

Function
REQ-012 State: DEPTH-entry circular storage, head and tail pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, occupancy counter 0..DEPTH.
REQ-013 in_ready = (DEPTH - count) >= WIDTH, derived from registered count only; freed space from same-cycle dequeue gives no credit.
REQ-014 Enqueue when in_ready and flush low: valid input slots written compacted, in slot order, starting at tail; tail += number of valid slots; stored valid bit forced 1.
REQ-015 Input groups with no valid slot, or presented while in_ready low, are ignored and not written; fetch holds them.
REQ-016 out_bundle[i] = entry at (head+i) mod DEPTH with valid = (i < count); combinational from registered state, zero-latency to decoder.
REQ-017 Dequeue: head += min(out_deq, valid output slots); out_deq exceeding valid slots is clamped, never underflows.
REQ-018 Simultaneous enqueue and dequeue: count_next = count + n_in - n_deq in the same edge.
REQ-019 Enqueue-to-output latency: one cycle (written at edge N, visible on out_bundle after edge N).
REQ-020 flush has highest priority: next state head = tail = count = 0; same-cycle enqueue and dequeue ignored.
REQ-021 During the flush cycle out_bundle still reflects pre-flush state; decoder discards it.
REQ-022 Pointer wrap-around: groups straddling DEPTH-1 -> 0 are stored and read contiguously in order.
REQ-023 Full boundary: count > DEPTH-WIDTH drops in_ready; count never exceeds DEPTH.

Reset
REQ-024 On rst assertion (asynchronous): head, tail, count = 0; in_ready = 1; all out_bundle valid = 0; stall_cnt = 0.
REQ-025 Storage payload is not reset; only valid-derived outputs are defined.
REQ-026 rst asserted mid-operation discards all entries identically to flush, without waiting for a clock edge.

Configuration
REQ-027 Macro FETQ_STAT_EN: when defined, stall_cnt port and counter exist; increments by 1 each cycle any in_bundle slot is valid and in_ready is low, saturating at 32'hFFFF_FFFF; cleared only by rst, not by flush.
REQ-028 Without FETQ_STAT_EN: no stall_cnt port, no counter logic; all other behaviour identical.

Verification
REQ-029 Reset, then two valid groups of 2 (PCs 0x1000..0x100C), out_deq=0 -> count=4; out_bundle slots 0/1 = PCs 0x1000/0x1004 valid.
REQ-030 Input slot0 invalid, slot1 valid PC 0x2000 into empty queue -> entry stored at index 0; next cycle out_bundle[0].pc=0x2000, valid; out_bundle[1] invalid.
REQ-031 Fill to count=7 (DEPTH=8) -> in_ready=0; held group not written; with FETQ_STAT_EN stall_cnt increments 1 per held cycle.
REQ-032 head=6, enqueue 4 bundles PCs 0x3000..0x300C while dequeuing 2 per cycle -> outputs 0x3000,0x3004,0x3008,0x300C in order across wrap.
REQ-033 count=1, out_deq=2 -> count=0 next cycle, head advanced by 1 only.
REQ-034 count=5, flush with valid input group and out_deq=2 same cycle -> next cycle count=0, in_ready=1, all outputs invalid, stall_cnt unchanged.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch queue: one fetched instruction bundle.
package fetch_queue_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } fet_bundle_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode side bundle interface of the fetch queue.
// master = fetch + decode side, slave = the queue.
interface fetch_queue_if #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) ();
  import fetch_queue_pkg::*;

  logic                         flush;
  fet_bundle_t [WIDTH-1:0]      in_bundle;
  logic                         in_ready;
  fet_bundle_t [WIDTH-1:0]      out_bundle;
  logic [$clog2(WIDTH+1)-1:0]   out_deq;
  logic [$clog2(DEPTH+1)-1:0]   count;

  modport master (
    output flush, in_bundle, out_deq,
    input  in_ready, out_bundle, count
  );

  modport slave (
    input  flush, in_bundle, out_deq,
    output in_ready, out_bundle, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Fetch queue: circular buffer between a WIDTH-wide fetch and a WIDTH-wide
// decoder. Valid input slots are compacted into the tail; the decoder sees
// the oldest WIDTH entries combinationally and reports how many it consumed.
// Optional feature macro: FETQ_STAT_EN adds the saturating stall_cnt output.
module fetch_queue #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.slave  q
`ifdef FETQ_STAT_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);
  import fetch_queue_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = $clog2(WIDTH + 1);

  fet_bundle_t             mem_q [DEPTH];
  logic [PW-1:0]           head_q, head_d;
  logic [PW-1:0]           tail_q, tail_d;
  logic [CW-1:0]           count_q, count_d;

  logic                    in_ready;
  logic [DW-1:0]           prefix [WIDTH+1];
  fet_bundle_t [WIDTH-1:0] cmp_data;
  fet_bundle_t [WIDTH-1:0] out_bundle;
  logic [DW-1:0]           n_in;
  logic [DW-1:0]           n_vld;
  logic [DW-1:0]           n_deq;
  logic                    any_vld;
  logic                    do_enq;

  // Space check uses registered occupancy only; same-cycle dequeue gives no credit.
  assign in_ready = (count_q <= CW'(DEPTH - WIDTH));
  assign any_vld  = (n_in != '0);
  assign do_enq   = in_ready && !q.flush && any_vld;

  assign q.in_ready   = in_ready;
  assign q.count      = count_q;
  assign q.out_bundle = out_bundle;

  // Compact valid input slots (program order kept) into the low slots.
  always_comb begin
    prefix   = '{default: '0};
    cmp_data = '0;
    for (int i = 0; i < WIDTH; i++) begin
      prefix[i+1] = prefix[i] + DW'(q.in_bundle[i].valid);
      for (int k = 0; k < WIDTH; k++) begin
        if (q.in_bundle[i].valid && (prefix[i] == DW'(k))) begin
          cmp_data[k]       = q.in_bundle[i];
          cmp_data[k].valid = 1'b1;
        end
      end
    end
    n_in = prefix[WIDTH];
  end

  // Present the oldest WIDTH entries; validity comes from occupancy, not storage.
  always_comb begin
    out_bundle = '0;
    for (int i = 0; i < WIDTH; i++) begin
      out_bundle[i]       = mem_q[head_q + PW'(i)];
      out_bundle[i].valid = (CW'(i) < count_q);
    end
  end

  // Clamp the decoder's consume count to the slots that are actually valid.
  always_comb begin
    n_vld = (count_q < CW'(WIDTH)) ? DW'(count_q) : DW'(WIDTH);
    n_deq = (q.out_deq < n_vld) ? q.out_deq : n_vld;
  end

  // Pointer and occupancy next state; flush overrides enqueue and dequeue.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (q.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(n_deq);
      count_d = count_q - CW'(n_deq);
      if (do_enq) begin
        tail_d  = tail_q + PW'(n_in);
        count_d = count_q + CW'(n_in) - CW'(n_deq);
      end
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage is intentionally not reset; only valid-derived outputs matter.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      for (int k = 0; k < WIDTH; k++) begin
        if (DW'(k) < n_in) begin
          mem_q[tail_q + PW'(k)] <= cmp_data[k];
        end
      end
    end
  end

`ifdef FETQ_STAT_EN
  logic [31:0] stall_q;

  // Count cycles where fetch offers work but the queue cannot take a group.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (any_vld && !in_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: the driver predicts accepted entries with
// a plain queue model, a negedge monitor compares the DUT window to it.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int W = 2;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.WIDTH(W), .DEPTH(D)) q ();

`ifdef FETQ_STAT_EN
  logic [31:0] stall_cnt;
`endif

  fetch_queue #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .q   (q)
`ifdef FETQ_STAT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb[$];
  logic [31:0] pend[$];
  bit          pend_flush = 0;
  bit          pend_stall = 0;
  logic [31:0] exp_stall  = '0;
  bit          mon_en     = 0;

  bit          st_fl;
  bit          st_v  [W];
  logic [31:0] st_pc [W];
  int          st_deq;
  logic [31:0] pc_next = 32'h4000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    q.flush = 1'b0;
    for (int i = 0; i < W; i++) q.in_bundle[i] = '0;
    q.out_deq = '0;
  endtask

  // Apply the previous cycle's prediction now that its edge has happened.
  task automatic commit();
    if (pend_flush) sb.delete();
    else foreach (pend[i]) sb.push_back(pend[i]);
    if (pend_stall && exp_stall != 32'hFFFF_FFFF) exp_stall++;
    pend.delete();
    pend_flush = 0;
    pend_stall = 0;
  endtask

  // One cycle of stimulus; prediction uses model occupancy after the last edge.
  task automatic step();
    bit any;
    bit room;
    @(posedge clk);
    #1;
    commit();
    q.flush   = st_fl;
    q.out_deq = st_deq[$clog2(W+1)-1:0];
    any = 0;
    for (int i = 0; i < W; i++) begin
      q.in_bundle[i].valid = st_v[i];
      q.in_bundle[i].pc    = st_pc[i];
      q.in_bundle[i].instr = ~st_pc[i];
      any |= st_v[i];
    end
    room       = (D - sb.size()) >= W;
    pend_flush = st_fl;
    pend_stall = any && !room;
    if (!st_fl && any && room)
      for (int i = 0; i < W; i++) if (st_v[i]) pend.push_back(st_pc[i]);
  endtask

  task automatic go(input bit fl, input bit v0, input logic [31:0] p0,
                    input bit v1, input logic [31:0] p1, input int deq);
    st_fl = fl; st_v[0] = v0; st_pc[0] = p0; st_v[1] = v1; st_pc[1] = p1; st_deq = deq;
    step();
  endtask

  task automatic go_grp(input logic [31:0] p0, input int deq);
    go(0, 1, p0, 1, p0 + 32'd4, deq);
  endtask

  task automatic go_idle(input int deq);
    go(0, 0, '0, 0, '0, deq);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(q.count), 32'd0);
    chk({tag, "_in_ready"}, 32'(q.in_ready), 32'd1);
    for (int i = 0; i < W; i++) chk({tag, "_out_valid"}, 32'(q.out_bundle[i].valid), 32'd0);
`ifdef FETQ_STAT_EN
    chk({tag, "_stall_cnt"}, stall_cnt, 32'd0);
`endif
  endtask

  // Monitor: compare the visible window with the model, then retire what decode takes.
  always @(negedge clk) begin : mon
    int sz;
    int n;
    if (mon_en && !rst) begin
      sz = sb.size();
      chk("count", 32'(q.count), 32'(sz));
      chk("in_ready", 32'(q.in_ready), 32'((D - sz) >= W));
      for (int i = 0; i < W; i++) begin
        chk("out_valid", 32'(q.out_bundle[i].valid), 32'(i < sz));
        if (i < sz) chk("out_pc", q.out_bundle[i].pc, sb[i]);
      end
`ifdef FETQ_STAT_EN
      chk("stall_cnt", stall_cnt, exp_stall);
`endif
      if (!q.flush) begin
        n = int'(q.out_deq);
        if (n > sz) n = sz;
        repeat (n) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    #12;
    chk_reset_state("reset");
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1;

    // Single valid slot in slot 1 lands at entry 0.
    go(0, 0, '0, 1, 32'h2000, 0);
    go_idle(1);
    // Two full groups, no dequeue.
    go_grp(32'h1000, 0);
    go_grp(32'h1008, 0);
    go_idle(0);
    // Fill to 7, then hold a group while not ready.
    go_grp(32'h1010, 0);
    go(0, 1, 32'h1018, 0, '0, 0);
    go_grp(32'h1020, 0);
    go_grp(32'h1020, 0);
    go_grp(32'h1020, 0);
    // Drain 7 -> 5 -> 3 -> 1, then over-ask on the last entry.
    go_idle(2);
    go_idle(2);
    go_idle(2);
    go_idle(2);
    go_idle(0);
    // Flush to known pointers, then walk head to 6 and enqueue across the wrap.
    go(1, 0, '0, 0, '0, 0);
    go_grp(32'h5000, 0);
    go_grp(32'h5008, 0);
    go_grp(32'h5010, 0);
    go_idle(2);
    go_idle(2);
    go_idle(2);
    go_grp(32'h3000, 2);
    go_grp(32'h3008, 2);
    go_idle(2);
    go_idle(2);
    // Count 5, then flush with a valid group and a dequeue in the same cycle.
    go_grp(32'h6000, 0);
    go_grp(32'h6008, 0);
    go(0, 1, 32'h6010, 0, '0, 0);
    go(1, 1, 32'h7000, 1, 32'h7004, 2);
    go_idle(0);
    go_idle(0);

    // Randomized traffic with an asynchronous reset in the middle.
    for (int c = 0; c < 400; c++) begin
      st_fl  = ($urandom_range(0, 19) == 0);
      st_deq = $urandom_range(0, W);
      for (int i = 0; i < W; i++) begin
        st_v[i]  = $urandom_range(0, 2) != 0;
        st_pc[i] = pc_next;
        pc_next += 32'd4;
      end
      step();
      if (c == 200) begin
        go_idle(0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        idle_inputs();
        #1;
        chk_reset_state("async_rst");
        sb.delete();
        pend.delete();
        pend_flush = 0;
        pend_stall = 0;
        exp_stall  = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
    end

    for (int c = 0; c < D; c++) go_idle(W);
    go_idle(0);
    @(negedge clk);
    #1;
    mon_en = 0;
    chk("final_count", 32'(q.count), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
